// File: rtl/time_demux.sv
// time_demux: rebuilds LANES parallel words from a WIDTH-bit time-multiplexed lane stream.
// Optional feature macro: TIME_DEMUX_ERRCNT_EN enables the saturating misaligned-sync counter on err_cnt.
module time_demux #(
  parameter  int WIDTH = 2,
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic [WIDTH-1:0]       din,
  output logic [LANES*WIDTH-1:0] out_bus,
  output logic                   frame_valid,
  output logic [CW-1:0]          slot,
  output logic                   sync_err,
  output logic [7:0]             err_cnt
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(LANES - 1);

  logic [WIDTH-1:0]       r_shadow [LANES-1];
  logic [LANES*WIDTH-1:0] r_out_bus;
  logic                   r_frame_valid;
  logic [CW-1:0]          r_slot;
  logic                   r_sync_err;

  logic                   w_last;
  logic                   w_misaligned;
  logic [LANES*WIDTH-1:0] w_frame;

  assign w_last       = (r_slot == LAST_SLOT);
  assign w_misaligned = en & sync & (r_slot != '0);

  // The final lane bypasses the shadow registers and goes straight from din into the frame.
  always_comb begin
    // NOTE: default assignment first so every path drives w_frame and no latch is inferred.
    w_frame = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
    end
    w_frame[(LANES-1)*WIDTH +: WIDTH] = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shadow registers are reset explicitly; they are few and a cleared
      // state keeps any partial frame from leaking after reset.
      for (int k = 0; k < LANES - 1; k++) begin
        r_shadow[k] <= '0;
      end
      r_out_bus     <= '0;
      r_frame_valid <= 1'b0;
      r_slot        <= '0;
      r_sync_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_frame_valid <= 1'b0;
      if (en) begin
        if (sync) begin
          // A sync always restarts the frame with din as lane 0; any partial frame is dropped.
          r_shadow[0] <= din;
          r_slot      <= CW'(1);
          if (w_misaligned) begin
            r_sync_err <= 1'b1;
          end
        end else if (w_last) begin
          r_out_bus     <= w_frame;
          r_frame_valid <= 1'b1;
          r_slot        <= '0;
        end else begin
          r_shadow[r_slot] <= din;
          r_slot           <= r_slot + CW'(1);
        end
      end
    end
  end

`ifdef TIME_DEMUX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturates at 255 and is cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_misaligned && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign out_bus     = r_out_bus;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_time_demux.sv
// Self-checking bench for time_demux: directed scenarios plus randomized traffic
// compared against a queue-based frame-assembly model.
module tb_time_demux;

  localparam int WIDTH = 2;
  localparam int LANES = 4;
  localparam int CW    = $clog2(LANES);
`ifdef TIME_DEMUX_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   en;
  logic                   sync;
  logic [WIDTH-1:0]       din;
  logic [LANES*WIDTH-1:0] out_bus;
  logic                   frame_valid;
  logic [CW-1:0]          slot;
  logic                   sync_err;
  logic [7:0]             err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the samples of the frame being collected, in lane order.
  logic [WIDTH-1:0]       m_q[$];
  logic [LANES*WIDTH-1:0] m_bus;
  logic                   m_fv;
  logic                   m_err;
  int                     m_cnt;

  time_demux #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .out_bus     (out_bus),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_bus = '0;
    m_fv  = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Drive one clock of stimulus, advance the model, and return #1 after the edge.
  task automatic step(input logic e, input logic s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    en = e; sync = s; din = d;
    @(posedge clk);
    m_fv = 1'b0;
    if (e) begin
      if (s) begin
        if (m_q.size() != 0) begin
          m_err = 1'b1;
          if (ERRCNT_ON && m_cnt < 255) m_cnt++;
        end
        m_q.delete();
        m_q.push_back(d);
      end else begin
        m_q.push_back(d);
        if (m_q.size() == LANES) begin
          for (int k = 0; k < LANES; k++) m_bus[k*WIDTH +: WIDTH] = m_q[k];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; sync = 1'b0; din = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; sync = 1'b0; din = '0;
    model_reset();
    #7;
    n_tests++;
    if (out_bus !== '0 || frame_valid !== 1'b0 || slot !== '0 || sync_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: bus=%h fv=%b slot=%0d serr=%b cnt=%0d, want all 0",
               out_bus, frame_valid, slot, sync_err, err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_first_frame();
    for (int n = 0; n < LANES; n++) begin
      step(1'b1, 1'b0, WIDTH'(n));
      if (n == LANES - 2) begin
        n_tests++;
        if (frame_valid !== 1'b0 || slot !== CW'(LANES - 1)) begin
          n_fail++;
          $display("FAIL first_frame_pre: fv=%b slot=%0d, want fv=0 slot=%0d", frame_valid, slot, LANES - 1);
        end
      end
    end
    n_tests++;
    if (out_bus !== 8'b11_10_01_00 || frame_valid !== 1'b1 || slot !== '0) begin
      n_fail++;
      $display("FAIL first_frame: bus=%b fv=%b slot=%0d, want 11100100 1 0", out_bus, frame_valid, slot);
    end
    step(1'b1, 1'b0, 2'd0);
    n_tests++;
    if (frame_valid !== 1'b0 || out_bus !== 8'b11_10_01_00) begin
      n_fail++;
      $display("FAIL first_frame_pulse: fv=%b bus=%b, want 0 and held 11100100", frame_valid, out_bus);
    end
  endtask

  task automatic test_chained_mux();
    int pulses;
    pulses = 0;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(1'b1, 1'b0, WIDTH'(3 - (n % LANES)));
      if (frame_valid === 1'b1) begin
        pulses++;
        n_tests++;
        if (out_bus !== 8'b00_01_10_11) begin
          n_fail++;
          $display("FAIL chain_bus: bus=%b, want 00011011", out_bus);
        end
      end
    end
    n_tests++;
    if (pulses != 3 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL chain_pulses: pulses=%0d serr=%b, want 3 0", pulses, sync_err);
    end
  endtask

  task automatic test_en_hold();
    do_reset();
    step(1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b0, 2'd2);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, WIDTH'($urandom));
      n_tests++;
      if (slot !== CW'(2) || frame_valid !== 1'b0 || out_bus !== '0) begin
        n_fail++;
        $display("FAIL en_hold: slot=%0d fv=%b bus=%h, want 2 0 00", slot, frame_valid, out_bus);
      end
    end
    step(1'b1, 1'b0, 2'd3);
    n_tests++;
    if (frame_valid !== 1'b0 || slot !== CW'(3)) begin
      n_fail++;
      $display("FAIL en_resume1: fv=%b slot=%0d, want 0 3", frame_valid, slot);
    end
    step(1'b1, 1'b0, 2'd0);
    n_tests++;
    if (frame_valid !== 1'b1 || out_bus !== 8'b00_11_10_01) begin
      n_fail++;
      $display("FAIL en_resume2: fv=%b bus=%b, want 1 00111001", frame_valid, out_bus);
    end
  endtask

  task automatic test_misaligned_sync();
    do_reset();
    step(1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b0, 2'd2);
    step(1'b1, 1'b1, 2'd3);
    n_tests++;
    if (slot !== CW'(1) || sync_err !== 1'b1 || frame_valid !== 1'b0 || err_cnt !== (ERRCNT_ON ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL sync_mid: slot=%0d serr=%b fv=%b cnt=%0d, want 1 1 0 %0d",
               slot, sync_err, frame_valid, err_cnt, ERRCNT_ON ? 1 : 0);
    end
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b0, 2'd2);
    n_tests++;
    if (frame_valid !== 1'b1 || out_bus !== 8'b10_01_00_11) begin
      n_fail++;
      $display("FAIL sync_frame: fv=%b bus=%b, want 1 10010011", frame_valid, out_bus);
    end
    step(1'b1, 1'b1, 2'd2);
    n_tests++;
    if (slot !== CW'(1) || sync_err !== 1'b1 || err_cnt !== (ERRCNT_ON ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL sync_aligned: slot=%0d serr=%b cnt=%0d, want 1 1 %0d",
               slot, sync_err, err_cnt, ERRCNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_sync_last_slot();
    do_reset();
    for (int n = 0; n < LANES - 1; n++) step(1'b1, 1'b0, 2'd3);
    step(1'b1, 1'b1, 2'd1);
    n_tests++;
    if (frame_valid !== 1'b0 || sync_err !== 1'b1 || slot !== CW'(1) || err_cnt !== (ERRCNT_ON ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL sync_last: fv=%b serr=%b slot=%0d cnt=%0d, want 0 1 1 %0d",
               frame_valid, sync_err, slot, err_cnt, ERRCNT_ON ? 1 : 0);
    end
    for (int n = 1; n < LANES; n++) step(1'b1, 1'b0, 2'd2);
    n_tests++;
    if (frame_valid !== 1'b1 || out_bus !== 8'b10_10_10_01) begin
      n_fail++;
      $display("FAIL sync_last_frame: fv=%b bus=%b, want 1 10101001", frame_valid, out_bus);
    end
  endtask

  task automatic test_saturate_and_async_reset();
    do_reset();
    for (int n = 0; n < 300; n++) step(1'b1, 1'b1, 2'd3);
    n_tests++;
    if (err_cnt !== (ERRCNT_ON ? 8'd255 : 8'd0) || sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: cnt=%0d serr=%b, want %0d 1", err_cnt, sync_err, ERRCNT_ON ? 255 : 0);
    end
    for (int n = 1; n < LANES; n++) step(1'b1, 1'b0, 2'd3);
    n_tests++;
    if (frame_valid !== 1'b1 || out_bus !== 8'hFF) begin
      n_fail++;
      $display("FAIL pre_async: fv=%b bus=%h, want 1 ff", frame_valid, out_bus);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (out_bus !== '0 || frame_valid !== 1'b0 || slot !== '0 || sync_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: bus=%h fv=%b slot=%0d serr=%b cnt=%0d, want all 0",
               out_bus, frame_valid, slot, sync_err, err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic e, s;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      e = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 9) == 0);
      step(e, s, WIDTH'($urandom));
      n_tests++;
      if (out_bus !== m_bus || frame_valid !== m_fv || slot !== CW'(m_q.size()) ||
          sync_err !== m_err || err_cnt !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL random[%0d]: bus=%h fv=%b slot=%0d serr=%b cnt=%0d, want %h %b %0d %b %0d",
                 n, out_bus, frame_valid, slot, sync_err, err_cnt,
                 m_bus, m_fv, m_q.size(), m_err, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_chained_mux();
    test_en_hold();
    test_misaligned_sync();
    test_sync_last_slot();
    test_saturate_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
